// File: rtl/opb_regbank_pkg.sv
// rtl/opb_regbank_pkg.sv - shared types and helpers for the OPB register bank
package opb_regbank_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACK,
    ST_DONE
  } state_t;

  // Commit request bit in the CTRL word, in OPB (MSB = 0) numbering.
  localparam int CTRL_COMMIT_BIT = 31;

  // Replace each byte lane of old_val whose enable is set; be[k] covers bits [8k+7:8k].
  function automatic logic [31:0] byte_merge(input logic [31:0] old_val,
                                             input logic [31:0] new_val,
                                             input logic [3:0]  be);
    logic [31:0] r;
    r = old_val;
    for (int k = 0; k < 4; k++) begin
      if (be[k]) r[8*k +: 8] = new_val[8*k +: 8];
    end
    return r;
  endfunction

  // OPB bit 0 is the MSB; renumber so that bit 0 becomes bit 31.
  function automatic logic [31:0] be_to_le32(input logic [0:31] v);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) r[31-i] = v[i];
    return r;
  endfunction

  // Byte-enable renumbering: OPB BE[0] (MSB lane) becomes bit 3.
  function automatic logic [3:0] be_to_le4(input logic [0:3] v);
    logic [3:0] r;
    for (int i = 0; i < 4; i++) r[3-i] = v[i];
    return r;
  endfunction

endpackage

// File: rtl/opb_regbank_decode.sv
// rtl/opb_regbank_decode.sv - address window hit and word index decode
module opb_regbank_decode #(
  parameter int                      C_OPB_AWIDTH = 32,
  parameter logic [C_OPB_AWIDTH-1:0] C_BASEADDR   = 32'h01000300,
  parameter logic [C_OPB_AWIDTH-1:0] C_HIGHADDR   = 32'h010003FF,
  parameter int                      IDX_W        = 6
) (
  input  logic [0:C_OPB_AWIDTH-1] abus,
  input  logic                    select,
  output logic                    hit,
  output logic [IDX_W-1:0]        idx
);

  logic [C_OPB_AWIDTH-1:0] addr;
  logic [C_OPB_AWIDTH-1:0] offset;
  logic                    unused_offset_bits;

  // Plain assignment keeps the numeric value; OPB bit 0 lands on the MSB.
  assign addr   = abus;
  assign offset = addr - C_BASEADDR;
  assign hit    = select && (addr >= C_BASEADDR) && (addr <= C_HIGHADDR);
  // Byte offset within a word is ignored; the window is word addressed.
  assign idx    = offset[IDX_W+1:2];

  assign unused_offset_bits = ^{offset[1:0], offset[C_OPB_AWIDTH-1:IDX_W+2]};

endmodule

// File: rtl/opb_register_bank_ppc2simulink.sv
// rtl/opb_register_bank_ppc2simulink.sv - OPB slave register bank with optional shadowed commit
module opb_register_bank_ppc2simulink
  import opb_regbank_pkg::*;
#(
  parameter logic [31:0] C_BASEADDR    = 32'h01000300,
  parameter logic [31:0] C_HIGHADDR    = 32'h010003FF,
  parameter int          C_OPB_AWIDTH  = 32,
  parameter int          C_OPB_DWIDTH  = 32,
  parameter int          C_NUM_REGS    = 4,
  parameter int          C_COMMIT_MODE = 0,
  parameter logic [31:0] C_RESET_VAL   = 32'h0,
  parameter string       C_FAMILY      = "virtex5"
) (
  input  logic                      OPB_Clk,
  input  logic                      OPB_Rst,
  input  logic [0:C_OPB_AWIDTH-1]   OPB_ABus,
  input  logic [0:3]                OPB_BE,
  input  logic [0:C_OPB_DWIDTH-1]   OPB_DBus,
  input  logic                      OPB_RNW,
  input  logic                      OPB_select,
  input  logic                      OPB_seqAddr,
  output logic [0:C_OPB_DWIDTH-1]   Sl_DBus,
  output logic                      Sl_xferAck,
  output logic                      Sl_errAck,
  output logic                      Sl_retry,
  output logic                      Sl_toutSup,
  output logic [32*C_NUM_REGS-1:0]  user_data_out,
  output logic [C_NUM_REGS-1:0]     user_update
);

  localparam int             WIN_WORDS = int'((C_HIGHADDR - C_BASEADDR) >> 2) + 1;
  localparam int             IDX_W     = $clog2(WIN_WORDS);
  localparam logic [IDX_W-1:0] CTRL_IDX = IDX_W'(C_NUM_REGS);
  localparam bit             SHADOWED  = (C_COMMIT_MODE == 1);

  state_t           state;
  logic             hit;
  logic [IDX_W-1:0] dec_idx;
  logic [IDX_W-1:0] idx_q;
  logic             rnw_q;
  logic [31:0]      rd_val;
  logic [31:0]      sl_dbus_q;
  logic             xfer_ack_q;
  logic [31:0]      active_q [C_NUM_REGS];
  logic [31:0]      shadow_q [C_NUM_REGS];
  logic             pending_q;
  logic [31:0]      wr_data;
  logic [3:0]       wr_be;
  logic             wr_cycle;
  logic             commit_req;
  logic             unused_ok;

  opb_regbank_decode #(
    .C_OPB_AWIDTH (C_OPB_AWIDTH),
    .C_BASEADDR   (C_OPB_AWIDTH'(C_BASEADDR)),
    .C_HIGHADDR   (C_OPB_AWIDTH'(C_HIGHADDR)),
    .IDX_W        (IDX_W)
  ) u_decode (
    .abus   (OPB_ABus),
    .select (OPB_select),
    .hit    (hit),
    .idx    (dec_idx)
  );

  assign wr_data    = be_to_le32(OPB_DBus);
  assign wr_be      = be_to_le4(OPB_BE);
  assign wr_cycle   = (state == ST_ACK) && !rnw_q;
  assign commit_req = SHADOWED && wr_cycle && (idx_q == CTRL_IDX) &&
                      OPB_DBus[CTRL_COMMIT_BIT] && OPB_BE[CTRL_COMMIT_BIT/8];

  // Readback value for the currently decoded index, captured when the transfer starts.
  always_comb begin
    rd_val = '0;
    for (int i = 0; i < C_NUM_REGS; i++) begin
      if (dec_idx == IDX_W'(i)) rd_val = SHADOWED ? shadow_q[i] : active_q[i];
    end
    if (SHADOWED && (dec_idx == CTRL_IDX)) rd_val[31-CTRL_COMMIT_BIT] = pending_q;
  end

  // Slave FSM: one-cycle ack after select, then a dead cycle while the master drops select.
  always_ff @(posedge OPB_Clk) begin
    if (OPB_Rst) begin
      state      <= ST_IDLE;
      xfer_ack_q <= 1'b0;
      sl_dbus_q  <= '0;
      idx_q      <= '0;
      rnw_q      <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (hit) begin
            state      <= ST_ACK;
            xfer_ack_q <= 1'b1;
            idx_q      <= dec_idx;
            rnw_q      <= OPB_RNW;
            sl_dbus_q  <= OPB_RNW ? rd_val : 32'h0;
          end
        end
        ST_ACK: begin
          state      <= ST_DONE;
          xfer_ack_q <= 1'b0;
          sl_dbus_q  <= '0;
        end
        ST_DONE: state <= ST_IDLE;
        default: begin
          state      <= ST_IDLE;
          xfer_ack_q <= 1'b0;
          sl_dbus_q  <= '0;
        end
      endcase
    end
  end

  // Register array: writes land on the ack edge; update strobes follow for one cycle.
  always_ff @(posedge OPB_Clk) begin
    if (OPB_Rst) begin
      for (int i = 0; i < C_NUM_REGS; i++) begin
        active_q[i] <= C_RESET_VAL;
        shadow_q[i] <= C_RESET_VAL;
      end
      pending_q   <= 1'b0;
      user_update <= '0;
    end else begin
      user_update <= '0;
      if (wr_cycle && (wr_be != 4'b0000)) begin
        for (int i = 0; i < C_NUM_REGS; i++) begin
          if (idx_q == IDX_W'(i)) begin
            if (SHADOWED) begin
              shadow_q[i] <= byte_merge(shadow_q[i], wr_data, wr_be);
              pending_q   <= 1'b1;
            end else begin
              active_q[i]    <= byte_merge(active_q[i], wr_data, wr_be);
              user_update[i] <= 1'b1;
            end
          end
        end
      end
      if (commit_req) begin
        for (int i = 0; i < C_NUM_REGS; i++) active_q[i] <= shadow_q[i];
        pending_q   <= 1'b0;
        user_update <= '1;
      end
    end
  end

  genvar g;
  generate
    for (g = 0; g < C_NUM_REGS; g++) begin : g_flat
      assign user_data_out[32*g +: 32] = active_q[g];
    end
  endgenerate

  assign Sl_DBus    = sl_dbus_q;
  assign Sl_xferAck = xfer_ack_q;
  assign Sl_errAck  = 1'b0;
  assign Sl_retry   = 1'b0;
  assign Sl_toutSup = 1'b0;
  assign unused_ok  = OPB_seqAddr;

endmodule

// File: tb/tb_opb_register_bank_ppc2simulink.sv
// tb/tb_opb_register_bank_ppc2simulink.sv - self-checking bench for the OPB register bank
module tb_opb_register_bank_ppc2simulink;

  localparam logic [31:0] BASE = 32'h01000300;
  localparam logic [31:0] HIGH = 32'h010003FF;
  localparam logic [31:0] RV   = 32'hA5A5A5A5;
  localparam int          NR   = 4;

  logic clk = 1'b0;
  logic rst;
  logic [0:31] abus;
  logic [0:3]  be;
  logic [0:31] dbus;
  logic rnw, sel0, sel1, seq;
  logic [0:31] sl_dbus0, sl_dbus1;
  logic ack0, ack1, err0, err1, retry0, retry1, tout0, tout1;
  logic [127:0] udata0, udata1;
  logic [3:0]   upd0, upd1;

  always #5 clk = ~clk;

  opb_register_bank_ppc2simulink #(.C_NUM_REGS(NR), .C_COMMIT_MODE(0), .C_RESET_VAL(RV)) dut0 (
    .OPB_Clk(clk), .OPB_Rst(rst), .OPB_ABus(abus), .OPB_BE(be), .OPB_DBus(dbus),
    .OPB_RNW(rnw), .OPB_select(sel0), .OPB_seqAddr(seq), .Sl_DBus(sl_dbus0),
    .Sl_xferAck(ack0), .Sl_errAck(err0), .Sl_retry(retry0), .Sl_toutSup(tout0),
    .user_data_out(udata0), .user_update(upd0));

  opb_register_bank_ppc2simulink #(.C_NUM_REGS(NR), .C_COMMIT_MODE(1), .C_RESET_VAL(RV)) dut1 (
    .OPB_Clk(clk), .OPB_Rst(rst), .OPB_ABus(abus), .OPB_BE(be), .OPB_DBus(dbus),
    .OPB_RNW(rnw), .OPB_select(sel1), .OPB_seqAddr(seq), .Sl_DBus(sl_dbus1),
    .Sl_xferAck(ack1), .Sl_errAck(err1), .Sl_retry(retry1), .Sl_toutSup(tout1),
    .user_data_out(udata1), .user_update(upd1));

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: architectural state of each bank
  logic [31:0] m_act [2][NR];
  logic [31:0] m_sh  [NR];
  logic        m_pend;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  function automatic logic get_ack(input int w);
    return (w == 0) ? ack0 : ack1;
  endfunction
  function automatic logic [31:0] get_sldbus(input int w);
    return (w == 0) ? sl_dbus0 : sl_dbus1;
  endfunction
  function automatic logic [127:0] get_udata(input int w);
    return (w == 0) ? udata0 : udata1;
  endfunction
  function automatic logic [3:0] get_upd(input int w);
    return (w == 0) ? upd0 : upd1;
  endfunction
  task automatic set_sel(input int w, input logic v);
    if (w == 0) sel0 = v; else sel1 = v;
  endtask

  function automatic logic [127:0] model_udata(input int w);
    return {m_act[w][3], m_act[w][2], m_act[w][1], m_act[w][0]};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NR; i++) begin
      m_act[0][i] = RV;
      m_act[1][i] = RV;
      m_sh[i]     = RV;
    end
    m_pend = 1'b0;
  endtask

  // Byte lane L (OPB numbering) is the L-th byte counted from the most significant end.
  function automatic logic [31:0] lane_merge(input logic [31:0] o, input logic [31:0] n, input logic [0:3] b);
    logic [31:0] r;
    r = o;
    for (int l = 0; l < 4; l++) if (b[l]) r[31-8*l -: 8] = n[31-8*l -: 8];
    return r;
  endfunction

  function automatic int word_idx(input logic [31:0] a);
    logic [31:0] off;
    off = a - BASE;
    return int'(off >> 2);
  endfunction

  function automatic logic [31:0] model_read(input int w, input logic [31:0] a);
    int k;
    k = word_idx(a);
    if (k < NR) return (w == 0) ? m_act[0][k] : m_sh[k];
    if (k == NR && w == 1) return {31'b0, m_pend};
    return 32'h0;
  endfunction

  // Applies a write to the model and returns the expected update strobe.
  task automatic model_write(input int w, input logic [31:0] a, input logic [0:3] b,
                             input logic [31:0] d, output logic [3:0] eu);
    int k;
    k  = word_idx(a);
    eu = 4'b0000;
    if (k < NR && b != 4'b0000) begin
      if (w == 0) begin
        m_act[0][k] = lane_merge(m_act[0][k], d, b);
        eu[k] = 1'b1;
      end else begin
        m_sh[k] = lane_merge(m_sh[k], d, b);
        m_pend  = 1'b1;
      end
    end else if (k == NR && w == 1 && b[3] && d[0]) begin
      for (int i = 0; i < NR; i++) m_act[1][i] = m_sh[i];
      m_pend = 1'b0;
      eu     = 4'b1111;
    end
  endtask

  // One complete in-window transfer; checks ack timing, data and strobes against the model.
  task automatic do_xfer(input int w, input logic r, input logic [31:0] a, input logic [0:3] b,
                         input logic [31:0] d, output logic [31:0] rd, output logic [3:0] us);
    int lat;
    logic got;
    logic [31:0] erd;
    logic [3:0]  eu;
    @(negedge clk);
    abus = a; be = b; dbus = d; rnw = r;
    set_sel(w, 1'b1);
    lat = 0; got = 1'b0; rd = '0; us = '0;
    while (!got && lat < 16) begin
      @(posedge clk); #1;
      lat++;
      if (get_ack(w)) got = 1'b1;
    end
    check("ack_latency", lat, 1);
    if (!got) begin
      set_sel(w, 1'b0);
      return;
    end
    rd  = get_sldbus(w);
    erd = model_read(w, a);
    @(posedge clk); #1;
    set_sel(w, 1'b0);
    us = get_upd(w);
    check("ack_one_cycle", get_ack(w), 0);
    check("dbus_idle", get_sldbus(w), 0);
    if (r) begin
      check("rdata", rd, erd);
      check("rd_no_update", us, 0);
    end else begin
      model_write(w, a, b, d, eu);
      check("update", us, eu);
      check("udata", get_udata(w), model_udata(w));
    end
    @(posedge clk); #1;
    check("update_cleared", get_upd(w), 0);
  endtask

  // Out-of-window access: select held 16 cycles, no ack and no state change expected.
  task automatic no_resp(input int w, input logic r, input logic [31:0] a);
    int acks;
    @(negedge clk);
    abus = a; be = 4'b1111; dbus = 32'hFFFFFFFF; rnw = r;
    set_sel(w, 1'b1);
    acks = 0;
    for (int c = 0; c < 16; c++) begin
      @(posedge clk); #1;
      if (get_ack(w)) acks++;
    end
    set_sel(w, 1'b0);
    check("outside_no_ack", acks, 0);
    check("outside_udata", get_udata(w), model_udata(w));
  endtask

  typedef struct {
    int          w;
    logic        r;
    logic [31:0] a;
    logic [0:3]  b;
    logic [31:0] d;
    int          ci;
    logic [31:0] ev;
    logic [3:0]  eu;
  } vec_t;

  vec_t tbl[$];

  initial begin
    logic [31:0] rd;
    logic [3:0]  us;
    int acks;
    logic drop;

    rst = 1'b1; abus = '0; be = '0; dbus = '0; rnw = 1'b0; sel0 = 1'b0; sel1 = 1'b0; seq = 1'b0;
    model_reset();

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_udata0", udata0, {4{RV}});
    check("rst_udata1", udata1, {4{RV}});
    check("rst_ack", {ack0, ack1}, 0);
    check("rst_update", {upd0, upd1}, 0);
    check("rst_dbus", {sl_dbus0, sl_dbus1}, 0);
    check("tied_zero", {err0, err1, retry0, retry1, tout0, tout1}, 0);
    @(negedge clk);
    rst = 1'b0;

    // Directed vectors: mode 0 then mode 1
    tbl.push_back('{0, 1'b0, BASE + 8,    4'b1111, 32'h12345678, 2, 32'h12345678, 4'b0100});
    tbl.push_back('{0, 1'b1, BASE + 8,    4'b1111, 32'h0,        0, 32'h12345678, 4'b0000});
    tbl.push_back('{0, 1'b1, BASE + 11,   4'b1111, 32'h0,        0, 32'h12345678, 4'b0000});
    tbl.push_back('{0, 1'b0, BASE + 0,    4'b1111, 32'h00000000, 0, 32'h00000000, 4'b0001});
    tbl.push_back('{0, 1'b0, BASE + 0,    4'b0010, 32'hFFFFFFFF, 0, 32'h0000FF00, 4'b0001});
    tbl.push_back('{0, 1'b0, BASE + 0,    4'b0000, 32'h12345678, 0, 32'h0000FF00, 4'b0000});
    tbl.push_back('{0, 1'b1, BASE + 0,    4'b1111, 32'h0,        0, 32'h0000FF00, 4'b0000});
    tbl.push_back('{0, 1'b0, BASE + 0,    4'b0100, 32'hFFFFFFFF, 0, 32'h00FFFF00, 4'b0001});
    tbl.push_back('{0, 1'b1, BASE + 16,   4'b1111, 32'h0,        0, 32'h00000000, 4'b0000});
    tbl.push_back('{0, 1'b0, BASE + 16,   4'b1111, 32'hFFFFFFFF, 0, 32'h00FFFF00, 4'b0000});
    tbl.push_back('{0, 1'b1, BASE + 20,   4'b1111, 32'h0,        0, 32'h00000000, 4'b0000});
    tbl.push_back('{0, 1'b0, BASE + 20,   4'b1111, 32'hFFFFFFFF, 0, 32'h00FFFF00, 4'b0000});
    tbl.push_back('{0, 1'b1, BASE + 252,  4'b1111, 32'h0,        0, 32'h00000000, 4'b0000});
    tbl.push_back('{1, 1'b0, BASE + 0,    4'b1111, 32'h11111111, 0, RV,           4'b0000});
    tbl.push_back('{1, 1'b0, BASE + 4,    4'b1111, 32'h22222222, 1, RV,           4'b0000});
    tbl.push_back('{1, 1'b1, BASE + 16,   4'b1111, 32'h0,        0, 32'h00000001, 4'b0000});
    tbl.push_back('{1, 1'b1, BASE + 0,    4'b1111, 32'h0,        0, 32'h11111111, 4'b0000});
    tbl.push_back('{1, 1'b0, BASE + 16,   4'b0001, 32'h00000001, 1, 32'h22222222, 4'b1111});
    tbl.push_back('{1, 1'b1, BASE + 16,   4'b1111, 32'h0,        0, 32'h00000000, 4'b0000});
    tbl.push_back('{1, 1'b1, BASE + 4,    4'b1111, 32'h0,        0, 32'h22222222, 4'b0000});
    tbl.push_back('{1, 1'b0, BASE + 12,   4'b1000, 32'hAB000000, 3, RV,           4'b0000});
    tbl.push_back('{1, 1'b0, BASE + 16,   4'b1111, 32'h00000000, 3, RV,           4'b0000});
    tbl.push_back('{1, 1'b0, BASE + 16,   4'b1110, 32'hFFFFFFFF, 3, RV,           4'b0000});
    tbl.push_back('{1, 1'b1, BASE + 16,   4'b1111, 32'h0,        0, 32'h00000001, 4'b0000});
    tbl.push_back('{1, 1'b0, BASE + 16,   4'b0001, 32'h00000001, 3, 32'hABA5A5A5, 4'b1111});

    foreach (tbl[n]) begin
      do_xfer(tbl[n].w, tbl[n].r, tbl[n].a, tbl[n].b, tbl[n].d, rd, us);
      if (tbl[n].r) check($sformatf("tbl%0d_rd", n), rd, tbl[n].ev);
      else check($sformatf("tbl%0d_word", n), get_udata(tbl[n].w)[32*tbl[n].ci +: 32], tbl[n].ev);
      check($sformatf("tbl%0d_upd", n), us, tbl[n].eu);
    end

    // Outside the window
    no_resp(0, 1'b0, HIGH + 4);
    no_resp(1, 1'b1, BASE - 4);

    // Reset during the ack cycle of a write, master keeps select until acked
    @(negedge clk);
    abus = BASE + 4; be = 4'b1111; dbus = 32'hDEADBEEF; rnw = 1'b0; sel0 = 1'b1;
    @(posedge clk); #1;
    check("mr_first_ack", ack0, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    check("mr_ack_dropped", ack0, 0);
    check("mr_udata_reset", udata0, {4{RV}});
    check("mr_udata1_reset", udata1, {4{RV}});
    acks = 0; drop = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); #1;
      if (drop) begin
        sel0 = 1'b0;
        drop = 1'b0;
        m_act[0][1] = 32'hDEADBEEF;
      end
      if (ack0) begin
        acks++;
        drop = 1'b1;
      end
    end
    sel0 = 1'b0;
    check("mr_single_ack", acks, 1);
    check("mr_write_landed", udata0, model_udata(0));

    // Randomized traffic against the model
    for (int n = 0; n < 60; n++) begin
      int w, kind;
      logic [31:0] a, d;
      logic [0:3] b;
      logic r;
      w    = int'($urandom % 2);
      kind = int'($urandom % 12);
      r    = 1'($urandom % 2);
      b    = 4'($urandom);
      d    = $urandom;
      if (kind < 7)       a = BASE + 4 * ($urandom % NR) + ($urandom % 4);
      else if (kind < 10) a = BASE + 4 * NR + ($urandom % 4);
      else if (kind < 11) a = BASE + 4 * $urandom_range(NR + 1, 63) + ($urandom % 4);
      else                a = ($urandom % 2) ? HIGH + 1 + ($urandom % 256) : BASE - 1 - ($urandom % 256);
      if (a < BASE || a > HIGH) no_resp(w, r, a);
      else do_xfer(w, r, a, b, d, rd, us);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
